truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequencer for a combinational function-under-test with N single-bit inputs and one output F, such as a 3-input {A,B,C} -> F block.
- Drives every input combination 0..2^N-1 in ascending order and waits a settle time per vector.
- Samples F into a 2^N-bit truth table, compares it against an expected table, and reports pass/fail with a start/done handshake.
- Sits between a bench or host controller and the combinational block. It replaces hand-written per-vector stimulus.

Parameters:
- N_INPUTS, 3, number of function inputs. Input vector width; table width is 2^N_INPUTS. Legal range 1..6.
- SETTLE_CYCLES, 1, extra cycles each vector is held before F is sampled. Hold per vector = SETTLE_CYCLES+1 cycles. Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- expected  input  2^N_INPUTS  reference table, bit k = expected F for input vector k; latched when start is accepted.
- f_in  input  1  F output of the function-under-test.
- vec_out  output  N_INPUTS  input vector driven to the function-under-test (MSB = A for N=3).
- busy  output  1  high while vectors are being driven.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  2^N_INPUTS  captured truth table, bit k = F sampled for vector k.
- fail  output  1  captured table differs from expected; valid from the done cycle onward.
- fail_index  output  N_INPUTS  lowest k where table_out[k] != expected[k]; 0 if fail=0.

Behaviour:
- Reset (reset=1 at rising edge) sets state=IDLE. It also clears vec_out, busy, done, table_out, fail, fail_index, the hold counter and the latched expected value.
- Reset has priority over every other input, including mid-sweep. A sweep interrupted by reset is abandoned and done is not pulsed.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, vec_out=0.
  - table_out, fail and fail_index hold their last results.
  - start=1 -> RUN. On the same edge: latch expected, clear table_out/fail/fail_index, set vec_out=0, clear the hold counter.
- RUN:
  - busy=1. vec_out=k is held for exactly SETTLE_CYCLES+1 cycles.
  - On the edge ending the last hold cycle of vector k: table_out[k] <= f_in. Then either vec_out <= k+1 with the counter cleared, or, if k = 2^N-1, go to DONE with vec_out <= 0.
  - start is ignored in RUN.
- DONE:
  - Lasts exactly one cycle. done=1, busy=0, vec_out=0.
  - table_out is complete. fail and fail_index are valid in this cycle and stay valid until the next accepted start.
  - Next state is IDLE. start asserted during DONE is ignored.
- Comparison:
  - fail = |(table_out ^ expected_latched).
  - fail_index = priority encode of the lowest set bit of the XOR.
  - Either register it on the edge entering DONE (using the final sampled bit), or compute it combinationally from registered values. Both must be valid in the DONE cycle.
- Latency: start sampled at edge t (in IDLE) -> RUN from cycle t+1. done=1 in cycle t+1+2^N*(SETTLE_CYCLES+1). For N=3, S=1 that is 17 cycles after the start edge.
- vec_out changes only on clock edges and is glitch-free registered output.
- Widths:
  - Hold counter is 4 bits, wrap not reachable.
  - Vector counter is N_INPUTS bits. Terminal detection uses an explicit compare to 2^N-1, not wrap-around.
- Back-to-back sweeps: start=1 in the first IDLE cycle after DONE is accepted. A minimum of one IDLE cycle separates sweeps.

Test Plan:
1. Bench model F = ~(A|B|C), N=3, S=1, expected=8'b00000001, start pulse -> vec_out visits 0..7, 2 cycles each; done pulses once at start+17; table_out=8'h01; fail=0; fail_index=0.
2. Same model, expected=8'b00000011 -> table_out=8'h01, fail=1, fail_index=1. busy was high for exactly 16 cycles.
3. Model F = A^B^C, S=0, expected=8'h96 -> each vector held 1 cycle; done at start+9; table_out=8'h96, fail=0. A start pulse during RUN is ignored: no restart, single done.
4. Reset asserted at vector 4 mid-sweep -> next cycle vec_out=0, busy=0, table_out=0, fail=0. No done pulse. A following start runs a full fresh sweep.
5. Model with F delayed by 1 cycle from vec_out, S=0 vs S=1 -> S=0 captures a shifted, wrong table (fail=1); S=1 captures the correct table (fail=0).
6. start held high continuously -> sweeps repeat with exactly one IDLE cycle between done and the next busy. Results are stable during IDLE.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Sweeps every input combination 0..2^N_INPUTS-1 into a combinational
// function-under-test. Each combination is held for SETTLE_CYCLES+1 cycles,
// then the function output is sampled into a truth table. The table is
// compared against a reference latched at start, and the result is reported.
//
// Handshake: start is a request that is accepted only in IDLE. An accepted
// start makes busy rise on the next cycle. done is a one-cycle pulse that
// marks completion. start is ignored while busy and during the done cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       sweep request, accepted in IDLE only
//   expected    reference table, bit k = expected F for vector k
//   f_in        output F of the function-under-test
//   vec_out     registered input vector driven to the function-under-test
//   busy        high while vectors are being driven
//   done        one-cycle completion pulse
//   table_out   captured truth table, bit k = F sampled for vector k
//   fail        captured table differs from the latched reference
//   fail_index  lowest mismatching vector, 0 when fail=0
//   state_dbg   current FSM state (0=IDLE, 1=RUN, 2=DONE)
module truth_table_sweeper #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [(1<<N_INPUTS)-1:0]   expected,
  input  logic                       f_in,
  output logic [N_INPUTS-1:0]        vec_out,
  output logic                       busy,
  output logic                       done,
  output logic [(1<<N_INPUTS)-1:0]   table_out,
  output logic                       fail,
  output logic [N_INPUTS-1:0]        fail_index,
  output logic [1:0]                 state_dbg
);

  localparam int                TW        = 1 << N_INPUTS;
  localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(TW - 1);
  localparam logic [3:0]        HOLD_LAST = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          hold_cnt;
  logic [TW-1:0]       exp_r;

  // Table as it will look after the current vector's sample is written.
  // The comparison is taken from this so fail/fail_index are registered on
  // the same edge that captures the final bit, and stay cleared during RUN.
  logic [TW-1:0]       next_table;
  logic [TW-1:0]       diff;
  logic [N_INPUTS-1:0] first_diff;
  logic                hold_end;

  assign hold_end  = (hold_cnt == HOLD_LAST);
  assign state_dbg = state;

  always_comb begin
    next_table          = table_out;
    next_table[vec_out] = f_in;
    diff                = next_table ^ exp_r;
    first_diff          = '0;
    // Scan downwards so the lowest set bit wins.
    for (int i = TW - 1; i >= 0; i--) begin
      if (diff[i]) first_diff = N_INPUTS'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vec_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= '0;
      fail       <= 1'b0;
      fail_index <= '0;
      hold_cnt   <= '0;
      exp_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          vec_out <= '0;
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            exp_r      <= expected;
            table_out  <= '0;
            fail       <= 1'b0;
            fail_index <= '0;
            hold_cnt   <= '0;
          end
        end

        RUN: begin
          if (hold_end) begin
            table_out <= next_table;
            hold_cnt  <= '0;
            if (vec_out == LAST_VEC) begin
              state      <= DONE;
              vec_out    <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              fail       <= |diff;
              fail_index <= first_diff;
            end else begin
              vec_out <= vec_out + 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end

        DONE: begin
          // Exactly one cycle; a start seen here is dropped.
          done    <= 1'b0;
          busy    <= 1'b0;
          vec_out <= '0;
          state   <= IDLE;
        end

        default: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          vec_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE_CYCLES=1 and 0) with
// N_INPUTS=3, each driving its own behavioural function-under-test.
// Function modes: 0 = ~(A|B|C), 1 = A^B^C, 2 = A^B^C delayed one cycle.
module tb_truth_table_sweeper;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] exp0 = '0, exp1 = '0;
  logic       f0, f1;
  logic [2:0] vec0, vec1;
  logic       busy0, busy1, done0, done1, fail0, fail1;
  logic [7:0] tbl0, tbl1;
  logic [2:0] idx0, idx1;
  logic [1:0] st0, st1;

  int mode0 = 0, mode1 = 0;
  logic dly0 = 1'b0, dly1 = 1'b0;

  function automatic logic fut(input int mode, input logic [2:0] v);
    case (mode)
      0:       fut = ~(v[2] | v[1] | v[0]);
      1:       fut = v[2] ^ v[1] ^ v[0];
      default: fut = 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    dly0 <= vec0[2] ^ vec0[1] ^ vec0[0];
    dly1 <= vec1[2] ^ vec1[1] ^ vec1[0];
  end

  assign f0 = (mode0 == 2) ? dly0 : fut(mode0, vec0);
  assign f1 = (mode1 == 2) ? dly1 : fut(mode1, vec1);

  truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .expected(exp0), .f_in(f0),
    .vec_out(vec0), .busy(busy0), .done(done0), .table_out(tbl0),
    .fail(fail0), .fail_index(idx0), .state_dbg(st0)
  );

  truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .expected(exp1), .f_in(f1),
    .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tbl1),
    .fail(fail1), .fail_index(idx1), .state_dbg(st1)
  );

  // Selected-instance view used by the shared sweep task.
  bit sel = 1'b1;
  logic [2:0] m_vec, m_idx;
  logic       m_busy, m_done, m_fail;
  logic [7:0] m_tbl;
  logic [1:0] m_st;
  assign m_vec  = sel ? vec1  : vec0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_fail = sel ? fail1 : fail0;
  assign m_tbl  = sel ? tbl1  : tbl0;
  assign m_idx  = sel ? idx1  : idx0;
  assign m_st   = sel ? st1   : st0;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, want);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v; else start0 = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         dsel;   // 1 = SETTLE 1 instance, 0 = SETTLE 0 instance
    int         mode;
    logic [7:0] expv;
    logic [7:0] tbl;
    logic       fl;
    logic [2:0] idx;
    int         lat;    // cycles from start edge to done cycle
    int         mid;    // cycle in which a stray start is pulsed (0 = none)
  } vec_t;

  vec_t vecs[7];

  // Drives one sweep and checks sequencing, latency and results.
  task automatic run_sweep(input vec_t v);
    int cyc, bcnt, vbad, s, stable_bad;
    bit got;
    logic [7:0] t_hold;
    sel = (v.dsel != 0);
    s = sel ? 1 : 0;
    if (sel) begin mode1 = v.mode; exp1 = v.expv; end
    else     begin mode0 = v.mode; exp0 = v.expv; end
    set_start(1'b1);
    step();
    set_start(1'b0);
    cyc = 1; bcnt = 0; vbad = 0; got = 0;
    while (cyc <= 40 && !got) begin
      if (m_done) got = 1;
      else begin
        if (m_busy) bcnt++;
        if (m_busy && m_vec != 3'((cyc - 1) / (s + 1))) vbad++;
        if (v.mid != 0 && cyc == v.mid) set_start(1'b1);
        else set_start(1'b0);
        step();
        cyc++;
      end
    end
    set_start(1'b0);
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(v.lat));
    check("busy_cycles", 32'(bcnt), 32'(8 * (s + 1)));
    check("vec_sequence_errs", 32'(vbad), 32'd0);
    check("busy_at_done", 32'(m_busy), 32'd0);
    check("vec_at_done", 32'(m_vec), 32'd0);
    check("state_at_done", 32'(m_st), 32'd2);
    exp_q.push_back(32'(v.tbl));
    check("table_out", 32'(m_tbl), exp_q.pop_front());
    check("fail", 32'(m_fail), 32'(v.fl));
    check("fail_index", 32'(m_idx), 32'(v.idx));
    // No second done, no restart, results held in IDLE.
    t_hold = m_tbl;
    stable_bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (m_done || m_busy || m_tbl != t_hold || m_fail != v.fl || m_idx != v.idx) stable_bad++;
    end
    check("idle_stable", 32'(stable_bad), 32'd0);
  endtask

  // ---------------- main ----------------
  initial begin
    int n, bad;
    bit got;

    vecs[0] = '{1, 0, 8'h01, 8'h01, 1'b0, 3'd0, 17, 0};
    vecs[1] = '{1, 0, 8'h03, 8'h01, 1'b1, 3'd1, 17, 0};
    vecs[2] = '{0, 1, 8'h96, 8'h96, 1'b0, 3'd0,  9, 4};
    vecs[3] = '{0, 2, 8'h96, 8'h2C, 1'b1, 3'd1,  9, 0};
    vecs[4] = '{1, 2, 8'h96, 8'h96, 1'b0, 3'd0, 17, 0};
    vecs[5] = '{1, 1, 8'h00, 8'h96, 1'b1, 3'd1, 17, 0};
    vecs[6] = '{0, 0, 8'h80, 8'h01, 1'b1, 3'd0,  9, 0};

    // Reset state
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("rst_vec1", 32'(vec1), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_table1", 32'(tbl1), 32'd0);
    check("rst_fail1", 32'(fail1), 32'd0);
    check("rst_idx1", 32'(idx1), 32'd0);
    check("rst_state1", 32'(st1), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_table0", 32'(tbl0), 32'd0);
    step();

    for (int i = 0; i < 7; i++) run_sweep(vecs[i]);

    // Reset mid-sweep at vector 4 on the SETTLE=1 instance (which holds fail=1).
    sel = 1'b1; mode1 = 0; exp1 = 8'h01;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    got = 0; n = 0;
    while (n < 30 && !got) begin
      if (vec1 == 3'd4) got = 1;
      else begin step(); n++; end
    end
    check("reached_vec4", 32'(got), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_vec", 32'(vec1), 32'd0);
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_table", 32'(tbl1), 32'd0);
    check("midrst_fail", 32'(fail1), 32'd0);
    check("midrst_state", 32'(st1), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (done1 || busy1) bad++;
      step();
    end
    check("midrst_no_done", 32'(bad), 32'd0);
    run_sweep(vecs[0]);

    // start held high: back-to-back sweeps with one IDLE cycle between.
    sel = 1'b1; mode1 = 1; exp1 = 8'h96;
    start1 = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      got = 0; n = 0;
      while (n < 40 && !got) begin
        step(); n++;
        if (done1) got = 1;
      end
      check("held_done_seen", 32'(got), 32'd1);
      step();
      check("held_idle_busy", 32'(busy1), 32'd0);
      check("held_idle_state", 32'(st1), 32'd0);
      check("held_idle_table", 32'(tbl1), 32'h96);
      check("held_idle_fail", 32'(fail1), 32'd0);
      step();
      check("held_restart_busy", 32'(busy1), 32'd1);
    end
    start1 = 1'b0;
    got = 0; n = 0;
    while (n < 40 && !got) begin
      step(); n++;
      if (done1) got = 1;
    end
    check("final_done_seen", 32'(got), 32'd1);
    step(); step();
    check("final_no_restart", 32'(busy1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
